pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: single-cycle pulse that releases the pipeline from IDLE.
REQ-004 SHALL have ports D_icode, E_icode, M_icode, input, 4 bits each: icodes held in the decode, execute and memory pipeline registers.
REQ-005 SHALL have ports d_srcA, d_srcB, E_dstM, input, 4 bits each: register IDs; 4'hF means none.
REQ-006 SHALL have port e_Cnd, input, 1 bit: execute-stage condition result.
REQ-007 SHALL have ports m_stat, W_stat, input, 4 bits each: one-hot status, with bit0 AOK, bit1 INS, bit2 HLT and bit3 ADR.
REQ-008 SHALL have ports F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, output, 1 bit each: pipeline register controls.
REQ-009 SHALL have ports halted, output, 1 bit, and cpu_stat, output, 4 bits: registered terminal status.
REQ-010 SHALL, with PERF_CNT_EN defined, add ports cyc_cnt, stall_cnt, bubble_cnt, output, 32 bits each.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DRAIN and HALT, held in a register.
REQ-012 IDLE SHALL drive F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, with all other controls 0; start=1 moves to RUN on the next edge.
REQ-013 RUN SHALL compute load_use = (E_icode==5 or 11) and E_dstM!=4'hF and (E_dstM==d_srcA or E_dstM==d_srcB).
REQ-014 RUN SHALL compute ret_haz = 9 present in any of D_icode, E_icode or M_icode.
REQ-015 RUN SHALL compute mispred = (E_icode==7) and e_Cnd==0.
REQ-016 In RUN: F_stall=load_use|ret_haz; D_stall=load_use; D_bubble=mispred|(ret_haz&~load_use); E_bubble=mispred|load_use.
REQ-017 In RUN, all hazard outputs SHALL be combinational from the inputs, with zero-cycle latency.
REQ-018 In RUN, m_stat!=AOK SHALL assert M_bubble in the same cycle and move to DRAIN on the next edge.
REQ-019 In RUN, W_stat!=AOK SHALL assert W_stall and move directly to HALT; if both excepting, W takes priority.
REQ-020 DRAIN SHALL drive F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1; it moves to HALT when W_stat!=AOK.
REQ-021 On entry to HALT, cpu_stat SHALL latch W_stat and halted SHALL become 1 on the same edge.
REQ-022 HALT SHALL drive F_stall=1, D_stall=1, W_stall=1, M_bubble=1; it is terminal and only rst_n exits it.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 A stall and a bubble SHALL never both be asserted to the same stage; load_use takes priority over bubble at D.

Reset
REQ-025 rst_n=0 SHALL immediately set state=IDLE, halted=0 and cpu_stat=4'b0001, and clear all counters.
REQ-026 Reset asserted mid-operation, including in DRAIN or HALT, SHALL abort with no residual state.

Configuration
REQ-027 Macro PERF_CNT_EN, when defined, SHALL compile in three counters active only in RUN and DRAIN.
REQ-028 cyc_cnt SHALL increment every such cycle.
REQ-029 stall_cnt SHALL increment when F_stall=1.
REQ-030 bubble_cnt SHALL increment when (D_bubble|E_bubble)=1.
REQ-031 Each counter SHALL saturate at 32'hFFFFFFFF.
REQ-032 Without PERF_CNT_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-033 Reset then no start for 5 cycles -> F_stall=1, E_bubble=1, halted=0, cpu_stat=4'b0001 throughout.
REQ-034 RUN, E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0 in the same cycle.
REQ-035 RUN, E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; with e_Cnd=1 -> all controls 0.
REQ-036 RUN, D_icode=9 for 3 cycles as ret advances -> F_stall=1 and D_bubble=1 each cycle, then 0 when M_icode!=9.
REQ-037 RUN, m_stat=4'b1000 then W_stat=4'b1000 next cycle -> M_bubble=1, then DRAIN, then HALT with cpu_stat=4'b1000 and halted=1; start pulse afterwards ignored.
REQ-038 PERF_CNT_EN, 10 RUN cycles containing one load_use and one mispred -> cyc_cnt=10, stall_cnt=1, bubble_cnt=2; rst_n pulse -> all 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Purpose : hazard/exception pipeline-control FSM (IDLE -> RUN -> DRAIN -> HALT).
// Latency : hazard controls are combinational (0 cycles); halted/cpu_stat update on the HALT-entry edge.
// Backpr. : none accepted; the block only drives stall/bubble controls into the pipeline registers.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start                      : one-cycle pulse, leaves IDLE (ignored elsewhere)
//   D_icode, E_icode, M_icode  : icodes held in the D, E and M pipeline registers
//   d_srcA, d_srcB, E_dstM     : register IDs, 4'hF = none
//   e_Cnd                      : execute-stage branch condition
//   m_stat, W_stat             : one-hot status {ADR,HLT,INS,AOK}
//   F_stall .. W_stall         : pipeline register stall/bubble controls
//   halted, cpu_stat           : registered terminal status
//   cyc_cnt, stall_cnt, bubble_cnt : saturating performance counters, present only
//                                with the PERF_CNT_EN macro defined
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  E_icode,
   input  logic [3:0]  M_icode,
   input  logic [3:0]  d_srcA,
   input  logic [3:0]  d_srcB,
   input  logic [3:0]  E_dstM,
   input  logic        e_Cnd,
   input  logic [3:0]  m_stat,
   input  logic [3:0]  W_stat,
   output logic        F_stall,
   output logic        D_stall,
   output logic        D_bubble,
   output logic        E_bubble,
   output logic        M_bubble,
   output logic        W_stall,
   output logic        halted,
   output logic [3:0]  cpu_stat
`ifdef PERF_CNT_EN
   ,
   output logic [31:0] cyc_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] bubble_cnt
`endif
);

   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] R_NONE   = 4'hF;
   localparam logic [3:0] S_AOK    = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   logic load_use;
   logic ret_haz;
   logic mispred;
   logic m_exc;
   logic w_exc;
   logic halt_entry;

   // Hazard detection is purely combinational from the pipeline-register contents.
   // load_use and mispred are mutually exclusive (different E_icode), so D never
   // sees a stall and a bubble together.
   assign load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                     (E_dstM != R_NONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign ret_haz  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
   assign mispred  = (E_icode == I_JXX) && !e_Cnd;
   assign m_exc    = (m_stat != S_AOK);
   assign w_exc    = (W_stat != S_AOK);

   always_comb begin
      state_d  = state_q;
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_stall  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            if (start) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            F_stall  = load_use | ret_haz;
            D_stall  = load_use;
            // a load-use stall holds D, so the ret bubble is deferred
            D_bubble = mispred | (ret_haz & ~load_use);
            E_bubble = mispred | load_use;
            M_bubble = m_exc;
            W_stall  = w_exc;
            // a faulting instruction in W is older than one in M, so it wins
            if (w_exc) begin
               state_d = ST_HALT;
            end else if (m_exc) begin
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            if (w_exc) begin
               state_d = ST_HALT;
            end
         end

         ST_HALT: begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            W_stall  = 1'b1;
            M_bubble = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign halt_entry = (state_d == ST_HALT) && (state_q != ST_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         halted   <= 1'b0;
         cpu_stat <= S_AOK;
      end else begin
         state_q <= state_d;
         // the excepting status is captured on the same edge that enters HALT
         if (halt_entry) begin
            halted   <= 1'b1;
            cpu_stat <= W_stat;
         end
      end
   end

`ifdef PERF_CNT_EN
   logic count_en;

   // counters only observe cycles where the pipeline is actually executing
   assign count_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt    <= '0;
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (count_en) begin
         if (cyc_cnt != 32'hFFFF_FFFF) begin
            cyc_cnt <= cyc_cnt + 32'd1;
         end
         if (F_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if ((D_bubble || E_bubble) && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose : randomized + directed bench for pipe_ctrl with a queue-based scoreboard.
// Latency : expectations are pushed when inputs are driven and popped on the following falling edge.
// Backpr. : none; one expectation per clock cycle.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  D_icode, E_icode, M_icode;
   logic [3:0]  d_srcA, d_srcB, E_dstM;
   logic        e_Cnd;
   logic [3:0]  m_stat, W_stat;
   logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
   logic        halted;
   logic [3:0]  cpu_stat;
`ifdef PERF_CNT_EN
   logic [31:0] cyc_cnt, stall_cnt, bubble_cnt;
`endif

   pipe_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .D_icode    (D_icode),
      .E_icode    (E_icode),
      .M_icode    (M_icode),
      .d_srcA     (d_srcA),
      .d_srcB     (d_srcB),
      .E_dstM     (E_dstM),
      .e_Cnd      (e_Cnd),
      .m_stat     (m_stat),
      .W_stat     (W_stat),
      .F_stall    (F_stall),
      .D_stall    (D_stall),
      .D_bubble   (D_bubble),
      .E_bubble   (E_bubble),
      .M_bubble   (M_bubble),
      .W_stall    (W_stall),
      .halted     (halted),
      .cpu_stat   (cpu_stat)
`ifdef PERF_CNT_EN
      ,
      .cyc_cnt    (cyc_cnt),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
   typedef struct {
      logic [5:0]  ctl;
      logic        hlt;
      logic [3:0]  cs;
      logic [31:0] cc;
      logic [31:0] sc;
      logic [31:0] bc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model: pipeline mode plus the architectural status it reports
   string       mode;
   logic        m_halted;
   logic [3:0]  m_cs;
   logic [31:0] m_cc, m_sc, m_bc;

   task automatic model_reset();
      mode     = "IDLE";
      m_halted = 1'b0;
      m_cs     = 4'b0001;
      m_cc     = 0;
      m_sc     = 0;
      m_bc     = 0;
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, want);
      end
   endtask

   // one clock cycle: drive inputs, predict outputs, let the edge happen, advance model
   task automatic step(input logic rst, input logic st,
                       input logic [3:0] di, input logic [3:0] ei, input logic [3:0] mi,
                       input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] dm,
                       input logic cnd, input logic [3:0] ms, input logic [3:0] ws);
      exp_t e;
      bit lu, rh, mp, fs, ds, db, eb, mb, wst;
      rst_n = rst; start = st;
      D_icode = di; E_icode = ei; M_icode = mi;
      d_srcA = sa; d_srcB = sb; E_dstM = dm;
      e_Cnd = cnd; m_stat = ms; W_stat = ws;
      if (!rst) model_reset();

      lu = ((ei == 5) || (ei == 11)) && (dm != 15) && ((dm == sa) || (dm == sb));
      rh = (di == 9) || (ei == 9) || (mi == 9);
      mp = (ei == 7) && !cnd;
      {fs, ds, db, eb, mb, wst} = 6'b0;
      if (mode == "IDLE" || mode == "DRAIN") begin
         fs = 1; db = 1; eb = 1; mb = 1;
      end else if (mode == "HALT") begin
         fs = 1; ds = 1; wst = 1; mb = 1;
      end else begin
         fs  = lu || rh;
         ds  = lu;
         db  = mp || (rh && !lu);
         eb  = mp || lu;
         mb  = (ms != 4'b0001);
         wst = (ws != 4'b0001);
      end
      e.ctl = {fs, ds, db, eb, mb, wst};
      e.hlt = m_halted; e.cs = m_cs;
      e.cc = m_cc; e.sc = m_sc; e.bc = m_bc;
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      if (rst) begin
         if (mode == "RUN" || mode == "DRAIN") begin
            m_cc = sat_inc(m_cc);
            if (fs) m_sc = sat_inc(m_sc);
            if (db || eb) m_bc = sat_inc(m_bc);
         end
         if (mode == "IDLE") begin
            if (st) mode = "RUN";
         end else if (mode == "RUN" || mode == "DRAIN") begin
            if (ws != 4'b0001) begin
               mode = "HALT"; m_halted = 1'b1; m_cs = ws;
            end else if (mode == "RUN" && ms != 4'b0001) begin
               mode = "DRAIN";
            end
         end
      end
   endtask

   task automatic quiet(input logic st);
      step(1, st, 0, 0, 0, 15, 15, 15, 1, 4'b0001, 4'b0001);
   endtask

   function automatic logic [3:0] rnd_reg();
      int v = $urandom_range(0, 4);
      return (v == 4) ? 4'hF : 4'(v);
   endfunction

   function automatic logic [3:0] rnd_stat();
      int v = $urandom_range(0, 99);
      if (v < 95) return 4'b0001;
      v = $urandom_range(1, 3);
      return 4'(1 << v);
   endfunction

   task automatic rand_step(input logic rst, input logic st);
      step(rst, st, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
           4'($urandom_range(0, 11)), rnd_reg(), rnd_reg(), rnd_reg(),
           1'($urandom_range(0, 1)), rnd_stat(), rnd_stat());
   endtask

   // monitor: every cycle the DUT presents its controls; compare against the queue head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ctrl{F_st,D_st,D_bb,E_bb,M_bb,W_st}",
                {26'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, {26'd0, e.ctl});
            chk("halted", {31'd0, halted}, {31'd0, e.hlt});
            chk("cpu_stat", {28'd0, cpu_stat}, {28'd0, e.cs});
`ifdef PERF_CNT_EN
            chk("cyc_cnt", cyc_cnt, e.cc);
            chk("stall_cnt", stall_cnt, e.sc);
            chk("bubble_cnt", bubble_cnt, e.bc);
`endif
         end
      end
   end

   initial begin
      model_reset();
      rst_n = 0; start = 0;
      D_icode = 0; E_icode = 0; M_icode = 0;
      d_srcA = 15; d_srcB = 15; E_dstM = 15;
      e_Cnd = 1; m_stat = 1; W_stat = 1;
      @(posedge clk);
      #1;

      // reset, then idle with no start
      step(0, 0, 0, 0, 0, 15, 15, 15, 1, 1, 1);
      step(0, 1, 0, 0, 0, 15, 15, 15, 1, 1, 1);
      for (int i = 0; i < 5; i++) quiet(0);
      quiet(1);                                                  // start -> RUN

      // ten RUN cycles: one load-use, one mispredict, ret walking down the pipe
      step(1, 0, 0, 5, 0, 3, 15, 3, 1, 1, 1);                    // load-use
      step(1, 0, 0, 7, 0, 15, 15, 15, 0, 1, 1);                  // mispredict
      step(1, 0, 0, 7, 0, 15, 15, 15, 1, 1, 1);                  // taken, no hazard
      step(1, 0, 9, 0, 0, 15, 15, 15, 1, 1, 1);                  // ret in D
      step(1, 0, 0, 9, 0, 15, 15, 15, 1, 1, 1);                  // ret in E
      step(1, 0, 0, 0, 9, 15, 15, 15, 1, 1, 1);                  // ret in M
      for (int i = 0; i < 4; i++) quiet(0);
      step(0, 0, 0, 0, 0, 15, 15, 15, 1, 1, 1);                  // reset pulse mid-run
      quiet(0);
      quiet(1);

      // exception in M, then W: drain then halt; start afterwards is ignored
      step(1, 0, 0, 0, 0, 15, 15, 15, 1, 4'b1000, 4'b0001);
      step(1, 0, 0, 0, 0, 15, 15, 15, 1, 4'b0001, 4'b0001);
      step(1, 0, 0, 0, 0, 15, 15, 15, 1, 4'b0001, 4'b1000);
      quiet(0);
      quiet(1);
      for (int i = 0; i < 3; i++) rand_step(1, 1'($urandom_range(0, 1)));
      step(0, 0, 0, 0, 0, 15, 15, 15, 1, 1, 1);                  // reset out of HALT

      // both stages excepting: W has priority, straight to HALT
      quiet(1);
      step(1, 0, 0, 0, 0, 15, 15, 15, 1, 4'b0010, 4'b0100);
      quiet(1);

      // randomized episodes, including occasional mid-run resets
      for (int ep = 0; ep < 25; ep++) begin
         step(0, 0, 0, 0, 0, 15, 15, 15, 1, 1, 1);
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) rand_step(1, 0);
         rand_step(1, 1);
         for (int k = 0; k < int'($urandom_range(20, 60)); k++)
            rand_step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0));
      end

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
